// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester-side and transmitter-side signals of uart_tx_arbiter.
//   master : arbiter view (drives ack/req_done/err and the tx_* controls).
//   slave  : environment view (requesters and the UART transmitter).
//   Signals:
//     en        global enable
//     req       per-requester send request (level)
//     req_data  byte for requester i at [8i+7:8i]
//     ack       one-hot 1-cycle pulse, byte accepted
//     req_done  one-hot 1-cycle pulse, frame finished
//     err       1-cycle pulse on watchdog abort
//     tx_en     transmitter enable
//     tx_start  transmitter start
//     tx_data   transmitter data_in
//     tx_busy   transmitter busy
//     tx_done   transmitter done (level)
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic                 en;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   req_done;
  logic                 err;
  logic                 tx_en;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    input  en, req, req_data, tx_busy, tx_done,
    output ack, req_done, err, tx_en, tx_start, tx_data
  );

  modport slave (
    output en, req, req_data, tx_busy, tx_done,
    input  ack, req_done, err, tx_en, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte producers. Requests are
//   granted round-robin; the granted byte is held on tx_data with tx_start
//   until the transmitter reports busy, completion is reported when done is
//   seen, and an idle gap of GAP_CYCLES done-low clocks separates frames.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   uart_tx_arbiter_if.master (requester and transmitter signals)
//   Parameters: NUM_REQ (2..8), GAP_CYCLES (1..255), TIMEOUT_CYCLES (16..65535).
//   Optional feature macro: UART_TX_ARB_TIMEOUT_EN adds a watchdog that aborts
//   a frame stuck in START/WAIT_DONE for TIMEOUT_CYCLES clocks and pulses err.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned GAP_W = 8;
  localparam int unsigned WD_W  = 16;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             r_state,    w_state_nxt;
  logic [PTR_W-1:0]   r_ptr,      w_ptr_nxt;
  logic [PTR_W-1:0]   r_owner,    w_owner_nxt;
  logic [GAP_W-1:0]   r_gap_cnt,  w_gap_cnt_nxt;
  logic [NUM_REQ-1:0] r_ack,      w_ack_nxt;
  logic [NUM_REQ-1:0] r_req_done, w_req_done_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic [7:0]         r_tx_data,  w_tx_data_nxt;
  logic               r_tx_en;

  logic               w_gnt_found;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_timeout;

  // Round-robin pick: first set request at or above the pointer, wrapping.
  always_comb begin : rr_pick
    int unsigned v_cand;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    v_cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_cand = 32'(r_ptr) + k;
      if (v_cand >= NUM_REQ) begin
        v_cand = v_cand - NUM_REQ;
      end
      if (!w_gnt_found && bus.req[v_cand[PTR_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = v_cand[PTR_W-1:0];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin : fsm_next
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_ack_nxt      = '0;
    w_req_done_nxt = '0;
    w_tx_start_nxt = r_tx_start;
    w_tx_data_nxt  = r_tx_data;

    unique case (r_state)
      S_IDLE: begin
        if (bus.en && w_gnt_found) begin
          w_tx_data_nxt  = bus.req_data[{w_gnt_idx, 3'b000} +: 8];
          w_tx_start_nxt = 1'b1;
          w_ack_nxt      = NUM_REQ'(1) << w_gnt_idx;
          w_owner_nxt    = w_gnt_idx;
          // Explicit wrap keeps non-power-of-two NUM_REQ in range.
          w_ptr_nxt      = (w_gnt_idx == PTR_LAST) ? '0 : w_gnt_idx + PTR_W'(1);
          w_state_nxt    = S_START;
        end
      end

      S_START: begin
        if (bus.tx_busy) begin
          w_tx_start_nxt = 1'b0;
          w_state_nxt    = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_tx_start_nxt = 1'b0;
          w_state_nxt    = S_GAP;
        end
      end

      S_WAIT_DONE: begin
        if (bus.tx_done) begin
          w_req_done_nxt = NUM_REQ'(1) << r_owner;
          w_state_nxt    = S_GAP;
        end else if (w_timeout) begin
          w_state_nxt    = S_GAP;
        end
      end

      S_GAP: begin
        // Only clocks with done low count toward the inter-frame gap.
        if (!bus.tx_done) begin
          if (r_gap_cnt == GAP_LAST) begin
            w_gap_cnt_nxt = '0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin : state_regs
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_gap_cnt  <= '0;
      r_ack      <= '0;
      r_req_done <= '0;
      r_tx_en    <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_ack      <= w_ack_nxt;
      r_req_done <= w_req_done_nxt;
      r_tx_en    <= bus.en;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt, w_wd_cnt_nxt;
  logic            r_err;
  logic            w_in_frame;
  logic            w_progress;
  logic            w_abort;

  assign w_in_frame = (r_state == S_START) || (r_state == S_WAIT_DONE);
  assign w_timeout  = w_in_frame && (r_wd_cnt == WD_LAST);
  // A handshake step on the same edge wins over the watchdog.
  assign w_progress = ((r_state == S_START)     && bus.tx_busy) ||
                      ((r_state == S_WAIT_DONE) && bus.tx_done);
  assign w_abort    = w_timeout && !w_progress;

  // Watchdog count: cleared on every state entry, saturating otherwise.
  always_comb begin : wd_next
    w_wd_cnt_nxt = r_wd_cnt;
    if (!w_in_frame || (w_state_nxt != r_state)) begin
      w_wd_cnt_nxt = '0;
    end else if (r_wd_cnt != '1) begin
      w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin : wd_regs
    if (rst) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_cnt_nxt;
      r_err    <= w_abort;
    end
  end

  assign bus.err = r_err;
`else
  // No watchdog built; TIMEOUT_CYCLES is never legally 0, so this folds to 0.
  assign w_timeout = (TIMEOUT_CYCLES == 0);
  assign bus.err   = 1'b0;
`endif

  assign bus.ack      = r_ack;
  assign bus.req_done = r_req_done;
  assign bus.tx_en    = r_tx_en;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;

endmodule
